// File: rtl/game_end_timer_scoreboard_pkg.sv
// Shared timing defaults, score width and FSM state encoding for the game-end timer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package game_end_timer_scoreboard_pkg;

  // Default timing so the game top and this block agree on the end-of-game hold time.
  localparam int PRESCALE_DEF       = 1000000;
  localparam int DURATION_TICKS_DEF = 50;
  localparam int SCORE_W_DEF        = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/game_tick_prescaler.sv
// Divides clk down to a one-cycle tick strobe every PRESCALE enabled cycles.
// Latency: tick is combinational from the registered count; restart takes effect next cycle.
// Backpressure: none; free-running while enable is high.
// Ports: clk, reset (sync, active-low), enable (count while high),
//        restart (reload count to 0, suppresses tick this cycle), tick (strobe out).
module game_tick_prescaler
  import game_end_timer_scoreboard_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(PRESCALE + 1);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  // A restart reloads the period, so any tick that would have landed here is dropped.
  assign tick = enable & ~restart & (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/game_end_timer_scoreboard.sv
// End-of-game hold timer plus saturating win/loss scoreboard and display blink strobe.
// Latency: running rises the cycle after start; high PRESCALE*DURATION_TICKS cycles.
// Backpressure: none; start/clear are single-cycle pulses, start while running restarts.
// Ports: clk, reset (sync, active-low), end_of_game_timer_start, game_won, clear_score;
//        end_of_game_timer_running, win_count, loss_count, last_won, result_valid, blink.
module game_end_timer_scoreboard
  import game_end_timer_scoreboard_pkg::*;
#(
  parameter int PRESCALE       = PRESCALE_DEF,
  parameter int DURATION_TICKS = DURATION_TICKS_DEF,
  parameter int SCORE_W        = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               end_of_game_timer_start,
  input  logic               game_won,
  input  logic               clear_score,
  output logic               end_of_game_timer_running,
  output logic [SCORE_W-1:0] win_count,
  output logic [SCORE_W-1:0] loss_count,
  output logic               last_won,
  output logic               result_valid,
  output logic               blink
);

  localparam int TW = $clog2(DURATION_TICKS + 1);
  localparam logic [TW-1:0]      TICK_DONE = TW'(DURATION_TICKS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  state_t        state, state_next;
  logic          start;
  logic          tick;
  logic          final_tick;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_cnt_inc;
  logic          blink_q;

  assign start = end_of_game_timer_start;

  game_tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (state == RUN),
    .restart(start),
    .tick   (tick)
  );

  // tick_cnt stays below DURATION_TICKS, so the increment never overflows TW bits.
  assign tick_cnt_inc = tick_cnt + TW'(1);
  assign final_tick   = tick & (tick_cnt_inc == TICK_DONE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (start)           state_next = RUN;
        else if (final_tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign end_of_game_timer_running = (state == RUN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt <= '0;
      blink_q  <= 1'b0;
    end else if (start || final_tick) begin
      tick_cnt <= '0;
      blink_q  <= 1'b0;
    end else if (tick) begin
      tick_cnt <= tick_cnt_inc;
      blink_q  <= ~blink_q;
    end
  end

  // Blink reflects the tick parity including the current cycle's tick, so a
  // one-tick run still shows a lit blink in its only running cycle.
  assign blink = end_of_game_timer_running & (blink_q ^ tick);

  // Scoreboard: when clear and start coincide, the clear lands first and the
  // new result is then counted on top of zeroed counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      win_count    <= '0;
      loss_count   <= '0;
      last_won     <= 1'b0;
      result_valid <= 1'b0;
    end else if (start) begin
      last_won     <= game_won;
      result_valid <= 1'b1;
      if (clear_score) begin
        win_count  <= game_won ? SCORE_ONE : '0;
        loss_count <= game_won ? '0 : SCORE_ONE;
      end else if (game_won) begin
        if (win_count != SCORE_MAX) win_count <= win_count + SCORE_ONE;
      end else begin
        if (loss_count != SCORE_MAX) loss_count <= loss_count + SCORE_ONE;
      end
    end else if (clear_score) begin
      win_count    <= '0;
      loss_count   <= '0;
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_game_end_timer_scoreboard.sv
module tb_game_end_timer_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, game_won, clear_score;
  logic       running, last_won, result_valid, blink;
  logic [1:0] win_count, loss_count;

  logic       m_start, m_won, m_clear;
  logic       m_running, m_last_won, m_valid, m_blink;
  logic [1:0] m_win, m_loss;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  game_end_timer_scoreboard #(
    .PRESCALE(4), .DURATION_TICKS(3), .SCORE_W(2)
  ) dut (
    .clk(clk), .reset(reset),
    .end_of_game_timer_start(start), .game_won(game_won), .clear_score(clear_score),
    .end_of_game_timer_running(running), .win_count(win_count), .loss_count(loss_count),
    .last_won(last_won), .result_valid(result_valid), .blink(blink)
  );

  game_end_timer_scoreboard #(
    .PRESCALE(1), .DURATION_TICKS(1), .SCORE_W(2)
  ) dut_min (
    .clk(clk), .reset(reset),
    .end_of_game_timer_start(m_start), .game_won(m_won), .clear_score(m_clear),
    .end_of_game_timer_running(m_running), .win_count(m_win), .loss_count(m_loss),
    .last_won(m_last_won), .result_valid(m_valid), .blink(m_blink)
  );

  typedef struct {
    int   rep;
    logic rst, st, gw, clr;
    logic e_run;
    int   e_win, e_loss;
    logic e_last, e_valid, e_blink;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int rep, input logic rst, st, gw, clr,
                     input logic e_run, input int e_win, e_loss,
                     input logic e_last, e_valid, e_blink);
    vec_t v;
    v.rep = rep; v.rst = rst; v.st = st; v.gw = gw; v.clr = clr;
    v.e_run = e_run; v.e_win = e_win; v.e_loss = e_loss;
    v.e_last = e_last; v.e_valid = e_valid; v.e_blink = e_blink;
    vecs.push_back(v);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic rst, st, gw, clr);
    reset = rst; start = st; game_won = gw; clear_score = clr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int hold;
  int exp_win;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    m_start = 1'b0; m_won = 1'b0; m_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_int("reset_main", {running, win_count, loss_count, last_won, result_valid, blink}, 0);
    check_int("reset_min", {m_running, m_win, m_loss, m_last_won, m_valid, m_blink}, 0);
    next_cycle();

    // Each row: rep, {reset,start,won,clear}, expected {run,win,loss,last,valid,blink}
    // observed during the same cycle the inputs are applied.
    // Basic loss run: running T+1..T+12, blink toggles at T+4, T+8, T+12.
    add(1, 1,1,0,0, 0,0,0,0,0,0);
    add(3, 1,0,0,0, 1,0,1,0,1,0);
    add(4, 1,0,0,0, 1,0,1,0,1,1);
    add(4, 1,0,0,0, 1,0,1,0,1,0);
    add(1, 1,0,0,0, 1,0,1,0,1,1);
    add(2, 1,0,1,0, 0,0,1,0,1,0);   // game_won without start is ignored
    // Clear alone while idle; last_won kept.
    add(1, 1,0,0,1, 0,0,1,0,1,0);
    add(1, 1,0,0,0, 0,0,0,0,0,0);
    // Restart: won at T, lost at T+6, running continuous through T+18.
    add(1, 1,1,1,0, 0,0,0,0,0,0);
    add(3, 1,0,0,0, 1,1,0,1,1,0);
    add(2, 1,0,0,0, 1,1,0,1,1,1);
    add(1, 1,1,0,0, 1,1,0,1,1,1);
    add(3, 1,0,0,0, 1,1,1,0,1,0);
    add(4, 1,0,0,0, 1,1,1,0,1,1);
    add(4, 1,0,0,0, 1,1,1,0,1,0);
    add(1, 1,0,0,0, 1,1,1,0,1,1);
    add(1, 1,0,0,0, 0,1,1,0,1,0);
    // Reach win=2/loss=1, then clear+start(lost) collides mid-run.
    add(1, 1,1,1,0, 0,1,1,0,1,0);
    add(1, 1,0,0,0, 1,2,1,1,1,0);
    add(1, 1,1,0,1, 1,2,1,1,1,0);
    add(3, 1,0,0,0, 1,0,1,0,1,0);
    add(1, 1,0,0,1, 1,0,1,0,1,1);   // clear alone mid-run, timer keeps going
    add(3, 1,0,0,0, 1,0,0,0,0,1);
    add(4, 1,0,0,0, 1,0,0,0,0,0);
    add(1, 1,0,0,0, 1,0,0,0,0,1);
    add(1, 1,0,0,0, 0,0,0,0,0,0);
    // Reset mid-run at T+5, then a full fresh 12-cycle loss run.
    add(1, 1,1,1,0, 0,0,0,0,0,0);
    add(3, 1,0,0,0, 1,1,0,1,1,0);
    add(1, 1,0,0,0, 1,1,0,1,1,1);
    add(1, 0,0,0,0, 1,1,0,1,1,1);
    add(2, 1,0,0,0, 0,0,0,0,0,0);
    add(1, 1,1,0,0, 0,0,0,0,0,0);
    add(3, 1,0,0,0, 1,0,1,0,1,0);
    add(4, 1,0,0,0, 1,0,1,0,1,1);
    add(4, 1,0,0,0, 1,0,1,0,1,0);
    add(1, 1,0,0,0, 1,0,1,0,1,1);
    add(1, 1,0,0,0, 0,0,1,0,1,0);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        drive(vecs[i].rst, vecs[i].st, vecs[i].gw, vecs[i].clr);
        @(negedge clk);
        checks++;
        if (running !== vecs[i].e_run || win_count !== 2'(vecs[i].e_win) ||
            loss_count !== 2'(vecs[i].e_loss) || last_won !== vecs[i].e_last ||
            result_valid !== vecs[i].e_valid || blink !== vecs[i].e_blink) begin
          failures++;
          $display("FAIL vec%0d.%0d got run=%b win=%0d loss=%0d last=%b valid=%b blink=%b exp run=%b win=%0d loss=%0d last=%b valid=%b blink=%b",
                   i, r, running, win_count, loss_count, last_won, result_valid, blink,
                   vecs[i].e_run, vecs[i].e_win, vecs[i].e_loss, vecs[i].e_last,
                   vecs[i].e_valid, vecs[i].e_blink);
        end
        next_cycle();
      end
    end

    // Saturation: clear, then four won games back to back after each run ends.
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    for (int g = 0; g < 4; g++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      next_cycle();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check_int($sformatf("sat_run_start%0d", g), running, 1);
      repeat (12) next_cycle();
      @(negedge clk);
      exp_win = (g + 1 > 3) ? 3 : g + 1;
      check_int($sformatf("sat_run_end%0d", g), running, 0);
      check_int($sformatf("sat_win%0d", g), win_count, exp_win);
      check_int($sformatf("sat_loss%0d", g), loss_count, 0);
      next_cycle();
    end

    // Minimal parameters in a closed loop with a game-master style handshake:
    // WON pulses start, WON_END waits on running, then START.
    m_start = 1'b1; m_won = 1'b1;
    @(negedge clk);
    check_int("min_not_yet_running", m_running, 0);
    next_cycle();
    m_start = 1'b0; m_won = 1'b0;
    @(negedge clk);
    check_int("min_running", m_running, 1);
    check_int("min_blink", m_blink, 1);
    check_int("min_win", m_win, 1);
    hold = 0;
    while (m_running === 1'b1 && hold < 20) begin
      hold++;
      @(posedge clk);
      @(negedge clk);
    end
    check_int("min_run_len", hold, 1);
    check_int("min_blink_idle", m_blink, 0);
    check_int("min_valid", m_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
